// File: rtl/stream_leaf_pkg.sv
// Shared constants and helpers for the stream_leaf FIFO slice.
package stream_leaf_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stream_leaf_ptr.sv
// Wrap-around FIFO pointer with enable and synchronous clear (clear wins).
module stream_leaf_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PTR_W'(1);
    end

endmodule

// File: rtl/stream_leaf_fifo.sv
// Leaf first-word-fall-through FIFO with occupancy count and threshold flags.
module stream_leaf_fifo
    import stream_leaf_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int AF_TH  = 3,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count,
    output logic              almost_full,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         push;
    logic                         pop;

    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AF_TH));
    assign in_ready    = !full && !rst;
    assign out_valid   = !empty;
    assign out_data    = mem[rd_ptr];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    stream_leaf_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    stream_leaf_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage survives a flush; out_data is meaningless while empty anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '0;
        else if (push && !flush)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic              hold_q;
    logic [DATA_W-1:0] hold_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= 1'b0;
            hold_data <= '0;
        end else begin
            hold_q    <= in_valid && !in_ready;
            hold_data <= in_data;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (count <= CNT_W'(DEPTH));
            assert (!(push && full));
            assert (!(pop && empty));
            if (hold_q && in_valid)
                assert (in_data == hold_data);
        end
    end
`endif

endmodule

// File: tb/tb_stream_leaf_fifo.sv
// Scoreboard bench for stream_leaf_fifo: a queue model tracks contents, flags and output order.
module tb_stream_leaf_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int AF_TH  = 3;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              full;
    logic              empty;

    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic              prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    stream_leaf_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: checks status against queue occupancy, then applies the edge's push/pop/flush.
    always @(negedge clk) begin
        int  sz;
        bit  do_push;
        bit  do_pop;
        sz = exp_q.size();
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            chk("in_ready",    {31'd0, in_ready},    {31'd0, sz < DEPTH});
            chk("out_valid",   {31'd0, out_valid},   {31'd0, sz > 0});
            chk("count",       32'(count),           32'(sz));
            chk("full",        {31'd0, full},        {31'd0, sz == DEPTH});
            chk("empty",       {31'd0, empty},       {31'd0, sz == 0});
            chk("almost_full", {31'd0, almost_full}, {31'd0, sz >= AF_TH});
            if (prev_hold && in_valid)
                chk("in_data_hold", 32'(in_data), 32'(prev_data));
            do_push   = in_valid && (sz < DEPTH);
            do_pop    = out_ready && (sz > 0);
            prev_hold = in_valid && !(sz < DEPTH);
            prev_data = in_data;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (do_pop) begin
                    chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
                    n_pop++;
                end
                if (do_push)
                    exp_q.push_back(in_data);
            end
        end
    end

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            tick();
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int pop_base;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        chk("reset_in_ready",  {31'd0, in_ready},    32'd0);
        chk("reset_out_valid", {31'd0, out_valid},   32'd0);
        chk("reset_out_data",  32'(out_data),        32'd0);
        chk("reset_count",     32'(count),           32'd0);
        chk("reset_empty",     {31'd0, empty},       32'd1);
        chk("reset_full",      {31'd0, full},        32'd0);
        chk("reset_af",        {31'd0, almost_full}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word falls through on the next cycle.
        in_valid = 1'b1; in_data = 8'hA1;
        tick();
        in_valid = 1'b0;
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_data",  32'(out_data),      32'hA1);
        chk("first_count", 32'(count),         32'd1);
        chk("first_empty", {31'd0, empty},     32'd0);
        drain();

        // Fill to full; fifth word must wait.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i);
            tick();
            if (i == 3) chk("af_at_3", {31'd0, almost_full}, 32'd1);
        end
        chk("full_at_4",     {31'd0, full},     32'd1);
        chk("ready_at_4",    {31'd0, in_ready}, 32'd0);
        chk("count_at_4",    32'(count),        32'd4);
        in_data = 8'h05;
        tick(); tick();
        chk("full_hold_cnt", 32'(count),   32'd4);
        chk("full_head",     32'(out_data), 32'h01);

        // One pop from full frees a slot; held word enters next cycle.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_full_cnt",   32'(count),         32'd3);
        chk("pop_full_ready", {31'd0, in_ready},  32'd1);
        chk("pop_full_head",  32'(out_data),      32'h02);
        tick();
        in_valid = 1'b0;
        chk("refill_cnt", 32'(count), 32'd4);
        drain();

        // Streaming with simultaneous push and pop.
        pop_base = n_pop;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'h10 + DATA_W'(i);
            tick();
            chk("stream_cnt", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("stream_pops",  32'(n_pop - pop_base), 32'd16);
        chk("stream_empty", {31'd0, empty},        32'd1);

        // Flush beats a same-cycle push.
        in_valid = 1'b1; in_data = 8'h30; tick();
        in_data = 8'h31; tick();
        chk("pre_flush_cnt", 32'(count), 32'd2);
        in_data = 8'h77; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_cnt",   32'(count),        32'd0);
        chk("flush_empty", {31'd0, empty},    32'd1);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h40 + DATA_W'(i);
            tick();
        end
        chk("pre_rst_cnt", 32'(count), 32'd3);
        in_data = 8'h43; out_ready = 1'b1;
        #2;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid},   32'd0);
        chk("arst_count",     32'(count),           32'd0);
        chk("arst_empty",     {31'd0, empty},       32'd1);
        chk("arst_in_ready",  {31'd0, in_ready},    32'd0);
        chk("arst_out_data",  32'(out_data),        32'd0);
        chk("arst_full",      {31'd0, full},        32'd0);
        chk("arst_af",        {31'd0, almost_full}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_count", 32'(count),        32'd0);
        tick(); tick();
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
